// File: rtl/router_pkg.sv
// Shared types and defaults for the serial router input port.
package router_pkg;

    localparam int ADDR_W_DEF = 1;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PAD,
        PAYLOAD,
        WAIT_OUT
    } in_state_e;

    typedef struct packed {
        logic last;
        logic data;
    } fifo_ent_t;

endpackage

// File: rtl/router_bit_fifo.sv
// Payload FIFO of {last, data} entries; the head entry is readable combinationally.
module router_bit_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  fifo_ent_t              wr_ent,
    input  logic                   rd_en,
    output fifo_ent_t              rd_ent,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    fifo_ent_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_wr, do_rd;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign count  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_rd  = rd_en && !empty;
    assign do_wr  = wr_en && (!full || do_rd);
    assign rd_ent = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/router_in_port.sv
// Router input port: parses address/pad/payload, requests the crossbar and drains a bit FIFO.
// Define ROUTER_IN_CNT_EN to add saturating packet and drop counters.
module router_in_port
    import router_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_n_i,
    input  logic              valid_n_i,
    input  logic              din,
    input  logic              grant_i,
    output logic [ADDR_W-1:0] dest_o,
    output logic              req_o,
    output logic              dout,
    output logic              frame_n_o,
    output logic              valid_n_o,
    output logic              err_o
`ifdef ROUTER_IN_CNT_EN
    ,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       drop_cnt_o
`endif
);
    localparam int CNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int AW    = $clog2(DEPTH);

    in_state_e         state_q, state_d;
    logic [CNT_W-1:0]  addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              req_q, req_d;
    logic              aborted_q, aborted_d;
    logic              drop_q, drop_d;
    logic              dout_q, dout_d;
    logic              frame_n_o_q, frame_n_o_d;
    logic              valid_n_o_q, valid_n_o_d;
    logic              err_q, err_d;

    fifo_ent_t   wr_ent, rd_ent;
    logic        want_wr, fifo_wr, pop, last_pop, full, empty, close_frame;
    logic [AW:0] count;

    assign wr_ent = '{last: frame_n_i, data: din};
    assign pop    = grant_i && !empty;
    // An aborted packet has no last flag stored; its end is the pop that empties the FIFO.
    assign last_pop = pop && (rd_ent.last || (aborted_q && count == {{AW{1'b0}}, 1'b1}));

    router_bit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (fifo_wr),
        .wr_ent (wr_ent),
        .rd_en  (pop),
        .rd_ent (rd_ent),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        dest_d      = dest_q;
        req_d       = req_q;
        aborted_d   = aborted_q;
        drop_d      = drop_q && !frame_n_i;
        err_d       = 1'b0;
        want_wr     = 1'b0;
        fifo_wr     = 1'b0;
        close_frame = 1'b0;

        case (state_q)
            IDLE: begin
                req_d     = 1'b0;
                aborted_d = 1'b0;
                if (!frame_n_i && !drop_q) begin
                    dest_d[0] = din;
                    if (ADDR_W == 1) begin
                        state_d = PAD;
                        req_d   = 1'b1;
                    end else begin
                        state_d    = ADDR;
                        addr_cnt_d = CNT_W'(1);
                    end
                end
            end
            ADDR: begin
                if (frame_n_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    dest_d[addr_cnt_q] = din;
                    if (addr_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d = PAD;
                        req_d   = 1'b1;
                    end else begin
                        addr_cnt_d = addr_cnt_q + 1'b1;
                    end
                end
            end
            PAD: begin
                if (!valid_n_i) begin
                    want_wr = 1'b1;
                    state_d = frame_n_i ? WAIT_OUT : PAYLOAD;
                end else if (frame_n_i) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            PAYLOAD: begin
                if (!valid_n_i) begin
                    want_wr = 1'b1;
                    if (frame_n_i) begin
                        state_d = WAIT_OUT;
                    end
                end else if (frame_n_i) begin
                    // Frame closed without a final valid bit: no last flag will ever drain.
                    err_d     = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (!drop_q && !frame_n_i) begin
                    err_d  = 1'b1;
                    drop_d = 1'b1;
                end
                if (last_pop) begin
                    state_d = IDLE;
                end else if (aborted_q && empty) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    close_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (want_wr) begin
            if (full && !pop) begin
                err_d     = 1'b1;
                aborted_d = 1'b1;
                drop_d    = !frame_n_i;
                state_d   = WAIT_OUT;
            end else begin
                fifo_wr = 1'b1;
            end
        end
    end

    always_comb begin
        dout_d      = 1'b0;
        valid_n_o_d = 1'b1;
        frame_n_o_d = frame_n_o_q;
        if (pop) begin
            dout_d      = rd_ent.data;
            valid_n_o_d = 1'b0;
            frame_n_o_d = last_pop;
        end else if (close_frame) begin
            frame_n_o_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            dest_q      <= '0;
            req_q       <= 1'b0;
            aborted_q   <= 1'b0;
            drop_q      <= 1'b0;
            dout_q      <= 1'b0;
            frame_n_o_q <= 1'b1;
            valid_n_o_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            dest_q      <= dest_d;
            req_q       <= req_d;
            aborted_q   <= aborted_d;
            drop_q      <= drop_d;
            dout_q      <= dout_d;
            frame_n_o_q <= frame_n_o_d;
            valid_n_o_q <= valid_n_o_d;
            err_q       <= err_d;
        end
    end

    assign dest_o    = dest_q;
    assign req_o     = req_q;
    assign dout      = dout_q;
    assign frame_n_o = frame_n_o_q;
    assign valid_n_o = valid_n_o_q;
    assign err_o     = err_q;

`ifdef ROUTER_IN_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if ((last_pop || close_frame) && pkt_cnt_q != 16'hFFFF) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (err_d && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_in_port.sv
// Directed bench for router_in_port: a DEPTH=16/ADDR_W=1 port and a DEPTH=4/ADDR_W=2 port.
module tb_router_in_port;

    typedef struct {
        logic       fr;
        logic       vl;
        logic       d;
        logic       gnt;
        logic [1:0] e_dest;
        logic       e_req;
        logic       e_dout;
        logic       e_fo;
        logic       e_vo;
        logic       e_err;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_n = 1'b1;
    logic valid_n = 1'b1;
    logic din = 1'b0;
    logic grant = 1'b0;
    logic sel = 1'b0;

    logic       fr_a, fr_b;
    logic [0:0] dest_a;
    logic [1:0] dest_b;
    logic       req_a, dout_a, fo_a, vo_a, err_a;
    logic       req_b, dout_b, fo_b, vo_b, err_b;
    logic [1:0] m_dest;
    logic       m_req, m_dout, m_fo, m_vo, m_err;
`ifdef ROUTER_IN_CNT_EN
    logic [15:0] pkt_a, drp_a, pkt_b, drp_b;
`endif

    int checks = 0;
    int failures = 0;
    row_t tbl [10];

    always #5 clk = ~clk;

    assign fr_a   = sel ? 1'b1 : frame_n;
    assign fr_b   = sel ? frame_n : 1'b1;
    assign m_dest = sel ? dest_b : {1'b0, dest_a};
    assign m_req  = sel ? req_b  : req_a;
    assign m_dout = sel ? dout_b : dout_a;
    assign m_fo   = sel ? fo_b   : fo_a;
    assign m_vo   = sel ? vo_b   : vo_a;
    assign m_err  = sel ? err_b  : err_a;

    router_in_port #(.ADDR_W(1), .DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_n_i(fr_a), .valid_n_i(valid_n), .din(din),
        .grant_i(grant), .dest_o(dest_a), .req_o(req_a), .dout(dout_a),
        .frame_n_o(fo_a), .valid_n_o(vo_a), .err_o(err_a)
`ifdef ROUTER_IN_CNT_EN
        , .pkt_cnt_o(pkt_a), .drop_cnt_o(drp_a)
`endif
    );

    router_in_port #(.ADDR_W(2), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_n_i(fr_b), .valid_n_i(valid_n), .din(din),
        .grant_i(grant), .dest_o(dest_b), .req_o(req_b), .dout(dout_b),
        .frame_n_o(fo_b), .valid_n_o(vo_b), .err_o(err_b)
`ifdef ROUTER_IN_CNT_EN
        , .pkt_cnt_o(pkt_b), .drop_cnt_o(drp_b)
`endif
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [1:0] e_dest, input logic e_req,
                           input logic e_dout, input logic e_fo, input logic e_vo, input logic e_err);
        chk({name, ".dest"}, m_dest, e_dest);
        chk({name, ".req"}, {1'b0, m_req}, {1'b0, e_req});
        chk({name, ".dout"}, {1'b0, m_dout}, {1'b0, e_dout});
        chk({name, ".frame_n_o"}, {1'b0, m_fo}, {1'b0, e_fo});
        chk({name, ".valid_n_o"}, {1'b0, m_vo}, {1'b0, e_vo});
        chk({name, ".err"}, {1'b0, m_err}, {1'b0, e_err});
    endtask

    // Apply inputs for one cycle, then sample just after the edge that consumed them.
    task automatic drive(input logic fr, input logic vl, input logic d, input logic g);
        frame_n = fr;
        valid_n = vl;
        din     = d;
        grant   = g;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].fr, tbl[i].vl, tbl[i].d, tbl[i].gnt);
            chk_out($sformatf("%s.r%0d", name, i), tbl[i].e_dest, tbl[i].e_req,
                    tbl[i].e_dout, tbl[i].e_fo, tbl[i].e_vo, tbl[i].e_err);
        end
        $display("txn %s: addr=1 pad=3 payload=1011 grant=1", name);
    endtask

    initial begin
        logic [9:0] p2;
        logic [5:0] p3;
        logic [5:0] p4;
        p2 = 10'b1100101101;
        p3 = 6'b011010;
        p4 = 6'b101101;

        //            fr    vl    d     gnt   dest   req   dout  fo    vo    err
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state of both ports
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0;
        chk_out("reset_a", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        sel = 1'b1;
        #1;
        chk_out("reset_b", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        sel = 1'b0;
        rst_n = 1'b1;
        drive(1, 1, 0, 0);

        run_table("basic");

        // Grant withheld: 10 bits buffered, then emitted back to back
        drive(0, 1, 0, 0);
        chk_out("hold.addr", 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(i == 9, 0, p2[i], 0);
            chk_out($sformatf("hold.in%0d", i), 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        repeat (6) begin
            drive(1, 1, 0, 0);
            chk_out("hold.wait", 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 1);
            chk_out($sformatf("hold.out%0d", i), 2'd0, 1'b1, p2[i], i == 9, 1'b0, 1'b0);
        end
        drive(1, 1, 0, 0);
        chk_out("hold.end", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        $display("txn hold: addr=0 payload=%b buffered then drained", p2);

        // Drop during drain, then a 2-cycle grant gap mid-output
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(i == 5, 0, p3[i], 0);
        end
        chk_out("gap.buffered", 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(0, 1, 1, 0);
        chk_out("gap.drop1", 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(0, 1, 1, 0);
        chk_out("gap.drop2", 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1, 1, 0, 0);
        chk_out("gap.drop3", 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 1);
            chk_out($sformatf("gap.out%0d", i), 2'd1, 1'b1, p3[i], 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0);
            chk_out($sformatf("gap.bubble%0d", i), 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int i = 2; i < 6; i++) begin
            drive(1, 1, 0, 1);
            chk_out($sformatf("gap.out%0d", i), 2'd1, 1'b1, p3[i], i == 5, 1'b0, 1'b0);
        end
        drive(1, 1, 0, 0);
        chk_out("gap.end", 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        $display("txn gap: addr=1 payload=%b with dropped frame and grant gap", p3);

        // Overflow on the DEPTH=4 port with a 2-bit address
        sel = 1'b1;
        drive(0, 1, 0, 0);
        chk_out("ovf.addr0", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(0, 1, 1, 0);
        chk_out("ovf.addr1", 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(i == 5, 0, p4[i], 0);
            chk_out($sformatf("ovf.in%0d", i), 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, i == 4);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1);
            chk_out($sformatf("ovf.out%0d", i), 2'd2, 1'b1, p4[i], i == 3, 1'b0, 1'b0);
        end
        drive(1, 1, 0, 1);
        chk_out("ovf.end", 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1, 1, 0, 1);
        chk_out("ovf.quiet", 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        $display("txn ovf: addr=2 payload=%b into depth 4", p4);
        sel = 1'b0;

        // Empty packet: address and padding, no payload
        drive(0, 1, 1, 1);
        chk_out("empty.addr", 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 1);
        drive(1, 1, 0, 1);
        chk_out("empty.err", 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) begin
            drive(1, 1, 0, 1);
            chk_out("empty.after", 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        $display("txn empty: addr=1 no payload");

        // Reset in the middle of a payload with 3 bits buffered
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0);
        chk_out("rst.pre", 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("rst.a", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        sel = 1'b1;
        #1;
        chk_out("rst.b", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        sel = 1'b0;
        frame_n = 1'b1;
        valid_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1, 0, 1);
        chk_out("rst.idle", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_table("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
